// File: rtl/accumulate_host_if.sv
// Stream-side bus of accumulate_host: command, load-data and readback handshakes.
interface accumulate_host_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 64
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] cmd_init_i;
  logic [DW-1:0] cmd_init_acc;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  // Fabric side: issues commands and load data, consumes readback.
  modport master (
    output cmd_valid, cmd_len, cmd_init_i, cmd_init_acc, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  // Host block side.
  modport slave (
    input  cmd_valid, cmd_len, cmd_init_i, cmd_init_acc, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/accumulate_host.sv
// Host-side initiator for the accumulate kernel: loads the kernel array,
// starts a run, waits for completion and streams back the first len words.
// Optional feature macro: ACC_HOST_TIMEOUT_EN (watchdog on the WAIT state).
module accumulate_host #(
  parameter int unsigned DEPTH = 1000,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 64
`ifdef ACC_HOST_TIMEOUT_EN
  , parameter int unsigned TMO = 16384
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  accumulate_host_if.slave       bus,
  output logic                   k_r_enable,
  output logic [AW-1:0]          k_init_i,
  output logic [DW-1:0]          k_init_acc,
  input  logic                   k_w_enable,
  input  logic                   k_result,
  output logic                   k_ctl,
  output logic                   k_we,
  output logic [AW-1:0]          k_addr,
  output logic [DW-1:0]          k_wdata,
  input  logic [DW-1:0]          k_rdata,
  output logic                   busy,
  output logic                   err,
  output logic                   result
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT, S_RA, S_RD, S_ERR
  } state_t;

`ifdef ACC_HOST_TIMEOUT_EN
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0] cnt_q;
  logic          tmo_hit;
`endif

  state_t        state_q, state_n;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] init_i_q;
  logic [DW-1:0] init_acc_q;
  logic [DW-1:0] hold_q;
  logic          held_q;
  logic          err_q;
  logic          result_q;

  logic          cmd_fire;
  logic          len_bad;
  logic          load_data;
  logic          load_step;
  logic          load_last;
  logic          drain_last;

  assign cmd_fire   = (state_q == S_IDLE) && bus.cmd_valid;
  assign len_bad    = (bus.cmd_len == '0) || (32'(bus.cmd_len) > DEPTH);
  assign load_data  = addr_q < len_q;
  assign load_step  = !load_data || bus.in_valid;
  assign load_last  = addr_q == AW'(DEPTH - 1);
  assign drain_last = addr_q == AW'(len_q - AW'(1));
`ifdef ACC_HOST_TIMEOUT_EN
  assign tmo_hit    = cnt_q == TW'(TMO - 1);
`endif

  assign k_init_i   = init_i_q;
  assign k_init_acc = init_acc_q;
  assign err        = err_q;
  assign result     = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (cmd_fire) state_n = len_bad ? S_ERR : S_LOAD;
      S_ERR:  state_n = S_IDLE;
      S_LOAD: if (load_step && load_last) state_n = S_KICK;
      S_KICK: state_n = S_WAIT;
      S_WAIT: begin
        if (k_w_enable) state_n = S_RA;
`ifdef ACC_HOST_TIMEOUT_EN
        else if (tmo_hit) state_n = S_IDLE;
`endif
      end
      S_RA:   state_n = S_RD;
      S_RD:   if (bus.out_ready) state_n = drain_last ? S_IDLE : S_RA;
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode; out_data passes k_rdata on the first RD cycle, then the held copy.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = held_q ? hold_q : k_rdata;
    k_r_enable    = 1'b0;
    k_ctl         = 1'b1;
    k_we          = 1'b0;
    k_addr        = addr_q;
    k_wdata       = '0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      S_LOAD: begin
        bus.in_ready = load_data;
        k_we         = load_data ? bus.in_valid : 1'b1;
        k_wdata      = load_data ? bus.in_data : '0;
      end
      S_KICK: begin
        k_ctl      = 1'b0;
        k_r_enable = 1'b1;
      end
      S_WAIT: k_ctl = 1'b0;
      S_RD: begin
        bus.out_valid = 1'b1;
        bus.out_last  = drain_last;
      end
      default: ;
    endcase
  end

  // Datapath: command latch, address counter, readback hold, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      init_i_q   <= '0;
      init_acc_q <= '0;
      hold_q     <= '0;
      held_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= 1'b0;
`ifdef ACC_HOST_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (cmd_fire) begin
          len_q      <= bus.cmd_len;
          init_i_q   <= bus.cmd_init_i;
          init_acc_q <= bus.cmd_init_acc;
          addr_q     <= '0;
          err_q      <= len_bad;
        end
        S_ERR:  err_q <= 1'b0;
        S_LOAD: if (load_step && !load_last) addr_q <= addr_q + AW'(1);
`ifdef ACC_HOST_TIMEOUT_EN
        S_KICK: cnt_q <= '0;
`endif
        S_WAIT: begin
          if (k_w_enable) begin
            result_q <= k_result;
            addr_q   <= '0;
          end
`ifdef ACC_HOST_TIMEOUT_EN
          else if (tmo_hit) err_q <= 1'b1;
          else              cnt_q <= cnt_q + TW'(1);
`endif
        end
        S_RD: begin
          if (!held_q) hold_q <= k_rdata;
          held_q <= !bus.out_ready;
          if (bus.out_ready && !drain_last) addr_q <= addr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_host.sv
// Directed bench for accumulate_host with a behavioural kernel model.
module tb_accumulate_host;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accumulate_host_if #(.AW(AW), .DW(DW)) bus ();

  logic          k_r_enable, k_w_enable, k_result, k_ctl, k_we;
  logic [AW-1:0] k_init_i, k_addr;
  logic [DW-1:0] k_init_acc, k_wdata, k_rdata;
  logic          busy, err, result;

  accumulate_host #(
    .DEPTH(1000), .AW(AW), .DW(DW)
`ifdef ACC_HOST_TIMEOUT_EN
    , .TMO(64)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .k_r_enable(k_r_enable), .k_init_i(k_init_i), .k_init_acc(k_init_acc),
    .k_w_enable(k_w_enable), .k_result(k_result), .k_ctl(k_ctl),
    .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata), .k_rdata(k_rdata),
    .busy(busy), .err(err), .result(result)
  );

  // Kernel model: array port with 1-cycle read, in-place running sum after r_enable.
  logic [DW-1:0] arr [0:1023];
  int            kcnt = 0;
  logic          kw_tie0 = 1'b0;
  logic          kres = 1'b0;
  logic signed [DW-1:0] kacc;
  initial begin
    k_w_enable = 1'b0;
    k_result   = 1'b0;
    k_rdata    = '0;
  end
  always @(posedge clk) begin
    k_rdata    <= arr[k_addr];
    k_w_enable <= 1'b0;
    if (k_ctl && k_we) arr[k_addr] <= k_wdata;
    if (k_r_enable && !kw_tie0) kcnt <= 5;
    else if (kcnt != 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) begin
        kacc = k_init_acc;
        for (int i = 0; i < 1000; i++) begin
          if (i >= int'(k_init_i)) begin
            kacc = kacc + arr[i];
            arr[i] <= kacc;
          end
        end
        k_w_enable <= 1'b1;
        k_result   <= kres;
      end
    end
  end

  // Activity monitor.
  int we_cnt = 0, we_zero = 0, ren_cnt = 0, ov_cnt = 0;
  always @(posedge clk) begin
    if (k_ctl && k_we) begin
      we_cnt <= we_cnt + 1;
      if (k_wdata == '0) we_zero <= we_zero + 1;
    end
    if (k_r_enable) ren_cnt <= ren_cnt + 1;
    if (bus.out_valid) ov_cnt <= ov_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [DW-1:0] din  [0:2];
  logic [DW-1:0] dexp [0:2];

  task automatic send_cmd(input int len, input int ii, input logic [DW-1:0] acc);
    @(negedge clk);
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = AW'(len);
    bus.cmd_init_i   = AW'(ii);
    bus.cmd_init_acc = acc;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_words(input int len);
    int n;
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = din[i];
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_wait", n < 50, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input int len, input int ii, input logic [DW-1:0] acc,
                     input int stall_idx, input int exp_zero, input logic exp_res);
    int n, b_we, b_z, b_r;
    logic [AW-1:0] a_hold;
    b_we = we_cnt; b_z = we_zero; b_r = ren_cnt;
    bus.out_ready = 1'b1;
    send_cmd(len, ii, acc);
    check("busy_run", busy, 1);
    check("cmd_ready_busy", bus.cmd_ready, 0);
    push_words(len);
    for (int k = 0; k < len; k++) begin
      if (k == stall_idx) bus.out_ready = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("out_wait", n < 3000, 1);
      check("out_data", bus.out_data, dexp[k]);
      check("out_last", bus.out_last, (k == len - 1) ? 1 : 0);
      if (k == stall_idx) begin
        a_hold = k_addr;
        repeat (10) begin
          @(negedge clk);
          check("stall_data", bus.out_data, dexp[k]);
          check("stall_addr", k_addr, a_hold);
        end
        check("stall_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_busy", busy, 0);
    check("done_cmd_ready", bus.cmd_ready, 1);
    check("done_out_valid", bus.out_valid, 0);
    check("result", result, exp_res);
    check("we_pulses", we_cnt - b_we, 1000);
    check("we_zero", we_zero - b_z, exp_zero);
    check("r_enable_pulses", ren_cnt - b_r, 1);
  endtask

  task automatic bad_cmd(input int len);
    int b_r;
    b_r = ren_cnt;
    send_cmd(len, 0, 64'd0);
    check("bad_err_set", err, 1);
    check("bad_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("bad_err_clear", err, 0);
    check("bad_idle", bus.cmd_ready, 1);
    check("bad_busy", busy, 0);
    check("bad_no_kick", ren_cnt - b_r, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_init_i = '0; bus.cmd_init_acc = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_r_enable", k_r_enable, 0);
    check("rst_k_ctl", k_ctl, 1);
    check("rst_k_we", k_we, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    // 5,7,9 with acc 1 from index 0 -> 6,13,22
    din[0] = 64'd5; din[1] = 64'd7; din[2] = 64'd9;
    dexp[0] = 64'd6; dexp[1] = 64'd13; dexp[2] = 64'd22;
    run(3, 0, 64'd1, -1, 997, 1'b0);
    // same run with readback stalled on the second word
    run(3, 0, 64'd1, 1, 997, 1'b0);

    // start at index 1, acc 0: arr[0] untouched, arr[1]=10; result bit 1 latched
    kres = 1'b1;
    din[0] = 64'd4; din[1] = 64'd10;
    dexp[0] = 64'd4; dexp[1] = 64'd10;
    run(2, 1, 64'd0, -1, 998, 1'b1);
    kres = 1'b0;

    bad_cmd(0);
    bad_cmd(1001);

    // reset in the middle of LOAD
    din[0] = 64'd5;
    send_cmd(3, 0, 64'd1);
    push_words(1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_k_ctl", k_ctl, 1);
    check("mid_rst_k_we", k_we, 0);
    rst = 1'b0;

    din[0] = 64'd5; din[1] = 64'd7; din[2] = 64'd9;
    dexp[0] = 64'd6; dexp[1] = 64'd13; dexp[2] = 64'd22;
    run(3, 0, 64'd1, -1, 997, 1'b0);

`ifdef ACC_HOST_TIMEOUT_EN
    begin
      int n, b_ov;
      kw_tie0 = 1'b1;
      b_ov = ov_cnt;
      din[0] = 64'd3;
      send_cmd(1, 0, 64'd0);
      push_words(1);
      n = 0;
      while (!k_r_enable && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("tmo_kick_wait", n < 2000, 1);
      n = 0;
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycles", n, 65);
      check("tmo_busy", busy, 0);
      check("tmo_no_out", ov_cnt - b_ov, 0);
      @(negedge clk);
      check("tmo_err_sticky", err, 1);
      kw_tie0 = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
